// File: rtl/mips_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM states, memory op codes and the
// default transaction timeout.
package mips_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StDBusy = 3'd1,
    StDDone = 3'd2,
    StFBusy = 3'd3,
    StFDone = 3'd4,
    StFDrop = 3'd5
  } arb_state_e;

  localparam logic MEM_OP_READ  = 1'b0;
  localparam logic MEM_OP_WRITE = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Unified memory port bus: the arbiter is the master, the memory is the slave.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_timeout_ctr.sv
// Transaction watchdog: counts cycles spent waiting for the memory and flags the cycle on which
// the count would reach TIMEOUT. TIMEOUT = 0 disables the flag.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the waiting cycle whose increment would land on TIMEOUT.
  assign tc = (TIMEOUT != 0) && en && (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and MEM-stage loads/stores. Data accesses
// win over fetches, a taken branch cancels an in-flight fetch, and every access has a watchdog.
module mem_port_arbiter import mips_pkg::*; #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_req,
  input  logic [ADDR_W-1:0]    if_addr,
  input  logic                 flush,
  output logic [DATA_W-1:0]    if_rdata,
  output logic                 if_valid,
  output logic                 stall_if,
  input  logic                 dm_read,
  input  logic                 dm_write,
  input  logic [ADDR_W-1:0]    dm_addr,
  input  logic [DATA_W-1:0]    dm_wdata,
  output logic [DATA_W-1:0]    dm_rdata,
  output logic                 dm_done,
  output logic                 stall_pipe,
  mem_port_arbiter_if.master   mem,
  output logic                 err
);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              err_q, err_d;
  logic              ctr_clr, ctr_en, timeout;

  assign ctr_en = (state_q == StDBusy) || (state_q == StFBusy) || (state_q == StFDrop);

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .tc    (timeout)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_rdata_d  = if_rdata_q;
    err_d       = err_q;
    ctr_clr     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (dm_read || dm_write) begin
          mem_req_d   = 1'b1;
          mem_we_d    = dm_write ? MEM_OP_WRITE : MEM_OP_READ;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          ctr_clr     = 1'b1;
          state_d     = StDBusy;
        end else if (if_req && !flush) begin
          mem_req_d  = 1'b1;
          mem_we_d   = MEM_OP_READ;
          mem_addr_d = if_addr;
          ctr_clr    = 1'b1;
          state_d    = StFBusy;
        end
      end
      StDBusy: begin
        if (mem.mem_ack) begin
          mem_req_d = 1'b0;
          if (mem_we_q == MEM_OP_READ) begin
            dm_rdata_d = mem.mem_rdata;
          end
          state_d = StDDone;
        end else if (timeout) begin
          mem_req_d  = 1'b0;
          err_d      = 1'b1;
          dm_rdata_d = '0;
          state_d    = StDDone;
        end
      end
      StFBusy: begin
        // An ack wins over a coincident flush; F_DONE then masks the pulse if flush persists.
        if (mem.mem_ack) begin
          mem_req_d  = 1'b0;
          if_rdata_d = mem.mem_rdata;
          state_d    = StFDone;
        end else if (timeout) begin
          mem_req_d  = 1'b0;
          err_d      = 1'b1;
          if_rdata_d = '0;
          state_d    = flush ? StIdle : StFDone;
        end else if (flush) begin
          state_d = StFDrop;
        end
      end
      StFDrop: begin
        if (mem.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = StIdle;
        end else if (timeout) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = StIdle;
        end
      end
      StDDone, StFDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dm_rdata_q  <= '0;
      if_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_rdata_q  <= if_rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

  assign dm_rdata   = dm_rdata_q;
  assign if_rdata   = if_rdata_q;
  assign err        = err_q;
  assign dm_done    = (state_q == StDDone);
  assign if_valid   = (state_q == StFDone) && !flush;
  assign stall_if   = if_req && !if_valid;
  assign stall_pipe = (dm_read || dm_write) && (state_q != StDDone);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus a randomized pipeline/memory
// model; expected responses are queued at issue time and checked by an independent monitor.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        is_read;
    logic [31:0] rdata;
  } dexp_t;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        flush;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        stall_if;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        stall_pipe;
  logic        err;

  logic        auto_slave;
  logic        auto_ack;
  logic [31:0] auto_rdata;
  logic        man_ack;
  logic [31:0] man_rdata;
  logic        stop;

  logic [31:0] bus_mem [512];
  logic [31:0] ref_mem [512];
  dexp_t       dq [$];
  logic [31:0] fq [$];

  int errors;
  int checks;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  assign mem_bus.mem_ack   = auto_slave ? auto_ack : man_ack;
  assign mem_bus.mem_rdata = auto_slave ? auto_rdata : man_rdata;

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .flush      (flush),
    .if_rdata   (if_rdata),
    .if_valid   (if_valid),
    .stall_if   (stall_if),
    .dm_read    (dm_read),
    .dm_write   (dm_write),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dm_done    (dm_done),
    .stall_pipe (stall_pipe),
    .mem        (mem_bus.master),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing, got none expected one", name);
  endtask

  // Memory slave: random 0..2 wait states, backed by bus_mem.
  initial begin
    int wait_left;
    wait_left  = -1;
    auto_ack   = 1'b0;
    auto_rdata = '0;
    for (int i = 0; i < 512; i++) bus_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      #1;
      if (!auto_slave || !rst_n || auto_ack) begin
        auto_ack  = 1'b0;
        wait_left = -1;
      end else if (mem_bus.mem_req) begin
        if (wait_left < 0) wait_left = int'($urandom_range(0, 2));
        if (wait_left == 0) begin
          auto_ack = 1'b1;
          if (mem_bus.mem_we) begin
            bus_mem[mem_bus.mem_addr[10:2]] = mem_bus.mem_wdata;
            auto_rdata = $urandom();
          end else begin
            auto_rdata = bus_mem[mem_bus.mem_addr[10:2]];
          end
        end else begin
          wait_left--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a completion.
  initial begin
    dexp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("stall_pipe", 32'(stall_pipe), 32'((dm_read | dm_write) & ~dm_done));
        chk("stall_if", 32'(stall_if), 32'(if_req & ~if_valid));
        if (dm_done) begin
          if (dq.size() == 0) fail("dm_done_unexpected");
          else begin
            e = dq.pop_front();
            if (e.is_read) chk("dm_rdata", dm_rdata, e.rdata);
          end
        end
        if (if_valid) begin
          if (fq.size() == 0) fail("if_valid_unexpected");
          else chk("if_rdata", if_rdata, fq.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    errors = 0; checks = 0;
    rst_n = 1'b0; if_req = 0; if_addr = 0; flush = 0;
    dm_read = 0; dm_write = 0; dm_addr = 0; dm_wdata = 0;
    auto_slave = 0; man_ack = 0; man_rdata = 0; stop = 0;
    for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);

    // Reset with a read pending and ack tied high.
    dm_read = 1; dm_addr = 32'h400; man_ack = 1; man_rdata = 32'hDEAD_BEEF;
    dq.push_back('{1'b1, 32'hDEAD_BEEF});
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_bus.mem_req), 0);
    chk("rst_mem_we", 32'(mem_bus.mem_we), 0);
    chk("rst_mem_addr", mem_bus.mem_addr, 0);
    chk("rst_mem_wdata", mem_bus.mem_wdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_dm_done", 32'(dm_done), 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_if_valid", 32'(if_valid), 0);
    chk("rst_err", 32'(err), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t1_req_c1", 32'(mem_bus.mem_req), 1);
    chk("t1_done_c1", 32'(dm_done), 0);
    @(negedge clk);
    chk("t1_done_c2", 32'(dm_done), 1);
    #1 dm_read = 0; man_ack = 0;

    // Write and fetch requested together: write first, fetch after.
    @(negedge clk);
    #1 if_req = 1; if_addr = 32'h10; dm_write = 1; dm_addr = 32'h600; dm_wdata = 32'h1234_5678;
    dq.push_back('{1'b0, 32'h0});
    fq.push_back(ref_mem[4]);
    @(negedge clk);
    chk("t2_req", 32'(mem_bus.mem_req), 1);
    chk("t2_we", 32'(mem_bus.mem_we), 1);
    chk("t2_addr", mem_bus.mem_addr, 32'h600);
    chk("t2_wdata", mem_bus.mem_wdata, 32'h1234_5678);
    repeat (2) begin
      @(negedge clk);
      chk("t2_req_held", 32'(mem_bus.mem_req), 1);
      chk("t2_stall_if", 32'(stall_if), 1);
    end
    #1 man_ack = 1;
    @(negedge clk);
    chk("t2_done", 32'(dm_done), 1);
    #1 dm_write = 0; man_ack = 0; man_rdata = ref_mem[4];
    @(negedge clk);
    chk("t2_gap_req", 32'(mem_bus.mem_req), 0);
    @(negedge clk);
    chk("t2_fetch_req", 32'(mem_bus.mem_req), 1);
    chk("t2_fetch_we", 32'(mem_bus.mem_we), 0);
    chk("t2_fetch_addr", mem_bus.mem_addr, 32'h10);
    #1 man_ack = 1;
    @(negedge clk);
    chk("t2_if_valid", 32'(if_valid), 1);
    #1 if_req = 0; man_ack = 0;

    // Flush during a fetch: dropped fetch, then refetch at the new PC.
    @(negedge clk);
    #1 if_req = 1; if_addr = 32'h20; man_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("t3_req", 32'(mem_bus.mem_req), 1);
    chk("t3_addr", mem_bus.mem_addr, 32'h20);
    #1 flush = 1; if_addr = 32'h40;
    fq.push_back(ref_mem[16]);
    @(negedge clk);
    chk("t3_drop_req", 32'(mem_bus.mem_req), 1);
    chk("t3_drop_addr", mem_bus.mem_addr, 32'h20);
    chk("t3_drop_valid", 32'(if_valid), 0);
    #1 flush = 0;
    @(negedge clk);
    chk("t3_drop_valid2", 32'(if_valid), 0);
    #1 man_ack = 1;
    @(negedge clk);
    chk("t3_after_req", 32'(mem_bus.mem_req), 0);
    chk("t3_after_valid", 32'(if_valid), 0);
    #1 man_ack = 0; man_rdata = ref_mem[16];
    @(negedge clk);
    chk("t3_refetch_addr", mem_bus.mem_addr, 32'h40);
    chk("t3_refetch_req", 32'(mem_bus.mem_req), 1);
    #1 man_ack = 1;
    @(negedge clk);
    chk("t3_refetch_valid", 32'(if_valid), 1);
    #1 if_req = 0; man_ack = 0;

    // Flush coincident with ack: F_DONE gates if_valid with the current flush.
    @(negedge clk);
    #1 if_req = 1; if_addr = 32'h44; man_rdata = ref_mem[17];
    @(negedge clk);
    chk("t4_req", 32'(mem_bus.mem_req), 1);
    #1 man_ack = 1; flush = 1;
    @(negedge clk);
    chk("t4_masked", 32'(if_valid), 0);
    #1 flush = 0; man_ack = 0;
    #1;
    chk("t4_unmasked", 32'(if_valid), 1);
    chk("t4_rdata", if_rdata, ref_mem[17]);
    if_req = 0;

    // Randomized pipeline traffic against the behavioural memory.
    @(negedge clk);
    #1 auto_slave = 1;
    fork
      begin : mem_stage
        int unsigned op, idx, waited;
        logic [31:0] wd;
        logic        done;
        for (int n = 0; n < 60; n++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          @(negedge clk);
          #1;
          op  = $urandom_range(0, 2);
          idx = 128 + $urandom_range(0, 15);
          wd  = $urandom();
          dm_addr  = idx << 2;
          dm_wdata = wd;
          dm_read  = (op != 1);
          dm_write = (op != 0);
          if (op == 0) dq.push_back('{1'b1, ref_mem[idx]});
          else begin
            dq.push_back('{1'b0, 32'h0});
            ref_mem[idx] = wd;
          end
          done = 0; waited = 0;
          while (!done && waited < 64) begin
            @(negedge clk);
            if (dm_done) done = 1;
            waited++;
          end
          if (!done) fail("dm_access_timeout");
          #1 dm_read = 0; dm_write = 0;
        end
        stop = 1;
      end
      begin : if_stage
        logic [31:0] pc;
        int          flush_left;
        pc = 0; flush_left = 0;
        if_addr = pc; if_req = 1;
        fq.push_back(ref_mem[0]);
        while (!stop) begin
          @(negedge clk);
          #1;
          if (flush_left > 0) begin
            flush_left--;
            if (flush_left == 0) flush = 0;
          end
          if (if_valid) begin
            pc = (pc + 32'd4) & 32'h1FC;
            if_addr = pc;
            fq.push_back(ref_mem[pc[10:2]]);
          end else if (flush_left == 0 && $urandom_range(0, 7) == 0) begin
            pc = 32'($urandom_range(0, 127)) << 2;
            if_addr = pc;
            flush = 1; flush_left = 2;
            fq.delete();
            fq.push_back(ref_mem[pc[10:2]]);
          end
          if_req = ($urandom_range(0, 5) != 0);
        end
        if_req = 0; flush = 0;
      end
    join
    repeat (10) @(negedge clk);
    chk("dq_drained", 32'(dq.size()), 0);
    for (int i = 128; i < 144; i++) chk("data_mem", bus_mem[i], ref_mem[i]);
    chk("rand_err", 32'(err), 0);

    // No ack at all: watchdog ends the read after 4 request cycles.
    #1 auto_slave = 0; man_ack = 0; man_rdata = 32'hFFFF_FFFF;
    fq.delete();
    @(negedge clk);
    #1 dm_read = 1; dm_addr = 32'h404;
    dq.push_back('{1'b1, 32'h0});
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_bus.mem_req) cnt++;
      if (dm_done) break;
    end
    chk("to_req_cycles", 32'(cnt), 4);
    chk("to_done", 32'(dm_done), 1);
    chk("to_err", 32'(err), 1);
    #1 dm_read = 0;
    repeat (3) @(negedge clk);
    chk("to_err_sticky", 32'(err), 1);

    // Reset in the middle of a write.
    #1 dm_write = 1; dm_addr = 32'h408; dm_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rb_req", 32'(mem_bus.mem_req), 1);
    #2 rst_n = 0;
    #1;
    chk("rb_mem_req", 32'(mem_bus.mem_req), 0);
    chk("rb_mem_we", 32'(mem_bus.mem_we), 0);
    chk("rb_mem_addr", mem_bus.mem_addr, 0);
    chk("rb_mem_wdata", mem_bus.mem_wdata, 0);
    chk("rb_if_rdata", if_rdata, 0);
    chk("rb_dm_rdata", dm_rdata, 0);
    chk("rb_err", 32'(err), 0);
    chk("rb_dm_done", 32'(dm_done), 0);
    dm_write = 0;
    @(negedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rb_idle_req", 32'(mem_bus.mem_req), 0);
    chk("rb_idle_done", 32'(dm_done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
